// File: rtl/ppu_clock_sequencer.sv
// PPU2 bring-up sequencer: generates the xin master clock, holds and releases PPU reset,
// and measures line/frame timing from the synchronized blanking outputs.
module ppu_clock_sequencer #(
    parameter int unsigned HALF_PERIOD  = 60,
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned COUNT_WIDTH  = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   ppu_hblank,
    input  logic                   ppu_vblank,
    output logic                   xin,
    output logic                   ppu_reset_n,
    output logic                   busy,
    output logic                   running,
    output logic [COUNT_WIDTH-1:0] line_cycles,
    output logic                   line_valid,
    output logic [COUNT_WIDTH-1:0] frame_lines,
    output logic                   frame_valid,
    output logic                   timeout
);

    localparam int unsigned DIV_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int unsigned RST_W = $clog2(RESET_CYCLES + 1);
    localparam logic [DIV_W-1:0]       DIV_LAST = DIV_W'(HALF_PERIOD - 1);
    localparam logic [RST_W-1:0]       RST_LAST = RST_W'(RESET_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] CTR_MAX  = '1;
    localparam logic [COUNT_WIDTH-1:0] CTR_ONE  = COUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        RESET_HOLD,
        RUN,
        STOPPING
    } state_t;

    state_t                 state;
    logic [DIV_W-1:0]       div_ctr;
    logic [RST_W-1:0]       rst_ctr;
    logic [1:0]             hb_sync;
    logic [1:0]             vb_sync;
    logic                   hb_prev;
    logic                   vb_prev;
    logic [COUNT_WIDTH-1:0] line_ctr;
    logic [COUNT_WIDTH-1:0] frame_ctr;
    logic                   line_armed;
    logic                   frame_armed;

    logic                   div_tc;
    logic                   xin_rise;
    logic                   hb_rise;
    logic                   vb_rise;
    logic                   start_ok;
    logic [COUNT_WIDTH-1:0] line_next;
    logic [COUNT_WIDTH-1:0] frame_next;

    assign div_tc     = (div_ctr == DIV_LAST);
    assign xin_rise   = (state != IDLE) && div_tc && !xin;
    assign hb_rise    = (state == RUN) && hb_sync[1] && !hb_prev;
    assign vb_rise    = (state == RUN) && vb_sync[1] && !vb_prev;
    assign start_ok   = (state == IDLE) && start && !stop;
    assign line_next  = line_ctr + CTR_ONE;
    assign frame_next = frame_ctr + CTR_ONE;

    // Two-flop synchronizers plus edge-detect history for the blanking pins
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hb_sync <= '0;
            vb_sync <= '0;
            hb_prev <= 1'b0;
            vb_prev <= 1'b0;
        end else begin
            hb_sync <= {hb_sync[0], ppu_hblank};
            vb_sync <= {vb_sync[0], ppu_vblank};
            hb_prev <= hb_sync[1];
            vb_prev <= vb_sync[1];
        end
    end

    // Divider and sequencing FSM; later assignments override the free-running divider
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            div_ctr     <= '0;
            rst_ctr     <= '0;
            xin         <= 1'b0;
            ppu_reset_n <= 1'b0;
            busy        <= 1'b0;
            running     <= 1'b0;
        end else begin
            if (state == IDLE) begin
                div_ctr <= '0;
                xin     <= 1'b0;
            end else if (div_tc) begin
                div_ctr <= '0;
                xin     <= ~xin;
            end else begin
                div_ctr <= div_ctr + DIV_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state   <= RESET_HOLD;
                        busy    <= 1'b1;
                        rst_ctr <= '0;
                    end
                end
                RESET_HOLD: begin
                    ppu_reset_n <= 1'b0;
                    if (stop) begin
                        state <= STOPPING;
                    end else if (xin_rise) begin
                        if (rst_ctr == RST_LAST) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end else begin
                            rst_ctr <= rst_ctr + RST_W'(1);
                        end
                    end
                end
                RUN: begin
                    ppu_reset_n <= 1'b1;
                    if (stop) begin
                        state       <= STOPPING;
                        running     <= 1'b0;
                        ppu_reset_n <= 1'b0;
                    end
                end
                default: begin
                    // Only leave once xin is low, so a high phase is never cut short
                    ppu_reset_n <= 1'b0;
                    if (!xin) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        xin     <= 1'b0;
                        div_ctr <= '0;
                    end else if (div_tc) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Line and frame measurement; results are retained until the next accepted start
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            line_ctr    <= '0;
            frame_ctr   <= '0;
            line_armed  <= 1'b0;
            frame_armed <= 1'b0;
            line_cycles <= '0;
            line_valid  <= 1'b0;
            frame_lines <= '0;
            frame_valid <= 1'b0;
            timeout     <= 1'b0;
        end else if (start_ok) begin
            line_ctr    <= '0;
            frame_ctr   <= '0;
            line_armed  <= 1'b0;
            frame_armed <= 1'b0;
            line_valid  <= 1'b0;
            frame_valid <= 1'b0;
            timeout     <= 1'b0;
        end else if (state == RUN) begin
            if (hb_rise) begin
                if (line_armed) begin
                    line_cycles <= line_ctr;
                    line_valid  <= 1'b1;
                end
                line_armed <= 1'b1;
                line_ctr   <= xin_rise ? CTR_ONE : '0;
            end else if (xin_rise && (line_ctr != CTR_MAX)) begin
                line_ctr <= line_next;
                if (line_next == CTR_MAX) begin
                    timeout <= 1'b1;
                end
            end

            if (vb_rise) begin
                if (frame_armed) begin
                    frame_lines <= frame_ctr;
                    frame_valid <= 1'b1;
                end
                frame_armed <= 1'b1;
                frame_ctr   <= hb_rise ? CTR_ONE : '0;
            end else if (hb_rise && (frame_ctr != CTR_MAX)) begin
                frame_ctr <= frame_next;
                if (frame_next == CTR_MAX) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ppu_clock_sequencer.sv
// Directed bench for ppu_clock_sequencer with HALF_PERIOD=2, RESET_CYCLES=3, COUNT_WIDTH=4.
module tb_ppu_clock_sequencer;

    localparam int unsigned CW = 4;

    logic          clock;
    logic          reset_n;
    logic          start;
    logic          stop;
    logic          ppu_hblank;
    logic          ppu_vblank;
    logic          xin;
    logic          ppu_reset_n;
    logic          busy;
    logic          running;
    logic [CW-1:0] line_cycles;
    logic          line_valid;
    logic [CW-1:0] frame_lines;
    logic          frame_valid;
    logic          timeout;

    int n_checks = 0;
    int n_fail   = 0;

    ppu_clock_sequencer #(
        .HALF_PERIOD (2),
        .RESET_CYCLES(3),
        .COUNT_WIDTH (CW)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .ppu_hblank (ppu_hblank),
        .ppu_vblank (ppu_vblank),
        .xin        (xin),
        .ppu_reset_n(ppu_reset_n),
        .busy       (busy),
        .running    (running),
        .line_cycles(line_cycles),
        .line_valid (line_valid),
        .frame_lines(frame_lines),
        .frame_valid(frame_valid),
        .timeout    (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Each line is 40 clocks (10 xin periods); vblank accompanies every vb_period-th hblank
    task automatic run_lines(input int first, input int n, input int vb_period);
        for (int i = first; i < first + n; i++) begin
            ppu_hblank = 1'b1;
            ppu_vblank = ((i % vb_period) == 0);
            step(8);
            ppu_hblank = 1'b0;
            ppu_vblank = 1'b0;
            step(32);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    logic prev_xin;
    logic found;

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        ppu_hblank = 1'b0;
        ppu_vblank = 1'b0;
        step(1);

        check("rst_xin", 32'(xin), 32'd0);
        check("rst_ppu_reset_n", 32'(ppu_reset_n), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_line_valid", 32'(line_valid), 32'd0);
        check("rst_frame_valid", 32'(frame_valid), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);

        reset_n = 1'b1;
        step(3);
        check("idle_xin_held", 32'(xin), 32'd0);

        // Bring-up: 3 xin rises in reset hold, release one clock after the third
        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        check("start_xin", 32'(xin), 32'd0);
        check("hold_ppu_reset_n", 32'(ppu_reset_n), 32'd0);
        step(2);
        check("xin_first_high", 32'(xin), 32'd1);
        step(2);
        check("xin_first_low", 32'(xin), 32'd0);
        step(6);
        check("third_rise_xin", 32'(xin), 32'd1);
        check("third_rise_running", 32'(running), 32'd1);
        check("third_rise_reset_still_low", 32'(ppu_reset_n), 32'd0);
        step(1);
        check("release_ppu_reset_n", 32'(ppu_reset_n), 32'd1);

        // Line/frame measurement
        run_lines(0, 1, 5);
        check("one_line_no_valid", 32'(line_valid), 32'd0);
        check("one_line_no_frame", 32'(frame_valid), 32'd0);
        run_lines(1, 5, 5);
        check("line_valid", 32'(line_valid), 32'd1);
        check("line_cycles", 32'(line_cycles), 32'd10);
        check("frame_valid", 32'(frame_valid), 32'd1);
        check("frame_lines", 32'(frame_lines), 32'd5);
        check("run_no_timeout", 32'(timeout), 32'd0);

        pulse_start();
        check("start_in_run_running", 32'(running), 32'd1);
        check("start_in_run_line_valid", 32'(line_valid), 32'd1);
        check("start_in_run_line_cycles", 32'(line_cycles), 32'd10);

        // Stop on the first clock of an xin high phase
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            prev_xin = xin;
            step(1);
            if (!prev_xin && xin) found = 1'b1;
        end
        check("found_xin_rise", 32'(found), 32'd1);
        pulse_stop();
        check("stopping_xin_high", 32'(xin), 32'd1);
        check("stopping_ppu_reset_n", 32'(ppu_reset_n), 32'd0);
        check("stopping_running", 32'(running), 32'd0);
        check("stopping_busy", 32'(busy), 32'd1);
        step(1);
        check("stopped_xin", 32'(xin), 32'd0);
        check("stopped_busy", 32'(busy), 32'd0);
        step(4);
        check("idle_xin_low", 32'(xin), 32'd0);
        check("retain_line_valid", 32'(line_valid), 32'd1);
        check("retain_line_cycles", 32'(line_cycles), 32'd10);
        check("retain_frame_lines", 32'(frame_lines), 32'd5);
        check("retain_frame_valid", 32'(frame_valid), 32'd1);

        // start and stop together in IDLE does nothing
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_busy", 32'(busy), 32'd0);
        step(4);
        check("start_stop_xin", 32'(xin), 32'd0);
        check("start_stop_line_valid", 32'(line_valid), 32'd1);

        // Stop during reset hold with xin low: back to IDLE without an xin pulse
        pulse_start();
        check("hold2_line_valid_cleared", 32'(line_valid), 32'd0);
        check("hold2_frame_valid_cleared", 32'(frame_valid), 32'd0);
        pulse_stop();
        check("hold_stop_busy", 32'(busy), 32'd1);
        check("hold_stop_xin", 32'(xin), 32'd0);
        step(1);
        check("hold_stop_idle", 32'(busy), 32'd0);
        check("hold_stop_xin_low", 32'(xin), 32'd0);
        step(3);
        check("hold_stop_xin_stays_low", 32'(xin), 32'd0);

        // Saturation: no hblank in RUN, line counter pins at 15
        pulse_start();
        step(10);
        check("sat_running", 32'(running), 32'd1);
        step(40);
        check("sat_not_yet", 32'(timeout), 32'd0);
        step(40);
        check("sat_timeout", 32'(timeout), 32'd1);
        check("sat_no_line_valid", 32'(line_valid), 32'd0);
        ppu_hblank = 1'b1;
        step(8);
        ppu_hblank = 1'b0;
        step(100);
        ppu_hblank = 1'b1;
        step(8);
        ppu_hblank = 1'b0;
        step(8);
        check("sat_line_valid", 32'(line_valid), 32'd1);
        check("sat_line_cycles", 32'(line_cycles), 32'd15);
        pulse_stop();
        step(4);
        check("sat_idle", 32'(busy), 32'd0);
        check("sat_timeout_sticky", 32'(timeout), 32'd1);
        pulse_start();
        check("clr_timeout", 32'(timeout), 32'd0);
        check("clr_line_valid", 32'(line_valid), 32'd0);
        check("clr_frame_valid", 32'(frame_valid), 32'd0);

        // Asynchronous reset mid-RUN with xin high
        step(11);
        check("arst_pre_running", 32'(running), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (xin) found = 1'b1;
            else step(1);
        end
        check("arst_found_xin_high", 32'(found), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_xin", 32'(xin), 32'd0);
        check("arst_ppu_reset_n", 32'(ppu_reset_n), 32'd0);
        check("arst_running", 32'(running), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        step(2);
        reset_n = 1'b1;
        step(3);
        check("post_arst_idle", 32'(busy), 32'd0);
        check("post_arst_xin", 32'(xin), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ppu_clock_sequencer.md
Name: ppu_clock_sequencer

Overview:
Sequences the PPU2 bring-up through the level shifters.
- Generates the `xin` master clock from the FPGA `clock` using a programmable divider.
- Holds the PPU in reset for a fixed number of `xin` cycles, then releases it, and supports a clean stop that never truncates an `xin` high phase.
- While running, measures line length (`xin` cycles per hblank) and frame length (hblanks per vblank) from the level-shifted PPU2 blanking outputs.
- Sits between the top-level bring-up wrapper (buttons/LEDs/host) and the PPU2 pins.

Parameters:
- `HALF_PERIOD`, 60: `clock` cycles per `xin` half-period; legal minimum is 1. `xin` period = 2*`HALF_PERIOD` clocks (100 kHz at 12 MHz).
- `RESET_CYCLES`, 16: `xin` rising edges with `ppu_reset_n` low before release; legal minimum is 1.
- `COUNT_WIDTH`, 16: width of the measurement counters.

Ports:
- `clock`, in, 1: system clock; the block's only clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: single-cycle request to begin the sequence.
- `stop`, in, 1: single-cycle request to stop.
- `ppu_hblank`, in, 1: PPU2 HBLANK, asynchronous to `clock`.
- `ppu_vblank`, in, 1: PPU2 VBLANK, asynchronous to `clock`.
- `xin`, out, 1: PPU master clock.
- `ppu_reset_n`, out, 1: PPU reset, active-low.
- `busy`, out, 1: 1 in every state except IDLE.
- `running`, out, 1: 1 only in RUN.
- `line_cycles`, out, `COUNT_WIDTH`: last measured `xin` cycles between hblank rising edges.
- `line_valid`, out, 1: `line_cycles` holds a measurement.
- `frame_lines`, out, `COUNT_WIDTH`: last measured hblank rises between vblank rising edges.
- `frame_valid`, out, 1: `frame_lines` holds a measurement.
- `timeout`, out, 1: sticky; a line or frame counter saturated.

Behaviour:
Reset (async, `reset_n`=0): all outputs 0, including `xin` and `ppu_reset_n`. State goes to IDLE and all counters and synchronizers clear.

Divider:
- Counter runs 0..`HALF_PERIOD`-1 in every state except IDLE.
- At the terminal count, `xin` toggles and the counter returns to 0.
- `xin_rise` is an internal one-cycle pulse on the cycle `xin` goes 0->1.
- In IDLE, the divider is held at 0 and `xin` at 0.

State machine (registered outputs):
- IDLE: on `start` -> RESET_HOLD. Clear `line_valid`, `frame_valid`, `timeout`, and the measurement counters.
- RESET_HOLD: `ppu_reset_n`=0. Count `xin_rise`; on the `RESET_CYCLES`-th rise -> RUN, and `ppu_reset_n`=1 from the next cycle.
- RUN: `ppu_reset_n`=1; measurement enabled. On `stop` -> STOPPING.
- STOPPING: `ppu_reset_n`=0 from the entry cycle.
  - If `xin`=0 on entry, go to IDLE the next cycle.
  - Otherwise keep dividing until the 1->0 toggle, then go to IDLE with `xin`=0.
- `stop` in RESET_HOLD -> STOPPING (same rules). `stop` in IDLE or STOPPING is ignored.
- `start` outside IDLE is ignored. `start` and `stop` asserted together: `stop` wins, and in IDLE nothing happens.

Input synchronization:
- `ppu_hblank` and `ppu_vblank` each pass through a 2-flop synchronizer.
- A rising edge is detected on the synchronized value, so an edge is seen 3 clocks after the pin changes.
- Edges are ignored outside RUN.

Line measurement (RUN only):
- `line_ctr` increments on `xin_rise` and saturates at all-ones. Reaching all-ones sets `timeout`.
- On an hblank rise:
  - If a previous hblank rise has occurred since entering RUN, load `line_cycles` with `line_ctr` and set `line_valid`.
  - Then `line_ctr` resets to 0, or to 1 if `xin_rise` occurs in the same cycle.
- The first hblank rise after entering RUN only arms the counter.

Frame measurement:
- Same scheme as line measurement: `frame_ctr` increments on hblank rise, and vblank rise loads `frame_lines` and sets `frame_valid`.
- The first vblank rise only arms.
- An hblank rise coincident with a vblank rise counts toward the new frame, so `frame_ctr` becomes 1.

Retention: measurements and valids hold their values through STOPPING and IDLE until the next accepted `start`. `timeout` is cleared only by `reset_n` or an accepted `start`.

Test Plan:
1. `HALF_PERIOD`=2, `RESET_CYCLES`=3; pulse `start` -> `busy`=1 next cycle; `xin` toggles every 2 clocks; `ppu_reset_n` rises 1 clock after the 3rd `xin` rise; `running`=1.
2. RUN with hblank rise every 10 `xin` rises -> first `line_valid` after the 2nd hblank, `line_cycles`=10. Vblank rise every 5 hblanks -> `frame_lines`=5 after the 2nd vblank.
3. `stop` while `xin`=1 mid-half-period -> `xin` completes its high phase, falls, state is IDLE and `xin` is held 0. `ppu_reset_n`=0 from the cycle after `stop`.
4. `start` and `stop` on the same cycle in IDLE -> remains IDLE. `start` during RUN -> ignored, measurements unchanged.
5. `COUNT_WIDTH`=4, no hblank in RUN -> `line_ctr` sticks at 15, `timeout`=1. Next `start` clears `timeout`, `line_valid` and `frame_valid`.
6. Assert `reset_n`=0 mid-RUN asynchronously -> `xin`, `ppu_reset_n`, `running` and `busy` all go 0 without waiting for a clock edge.
